// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared types and constants for the uart transmit arbiter
package uart_arb_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4,
        HOLD  = 3'd5
    } arb_state_t;

    localparam int DEFAULT_START_TIMEOUT = 1000;
    localparam int DEFAULT_HOLD_TIMEOUT  = 2_000_000;

    // Width of a requester index; a lone bit is still needed for two requesters.
    function automatic int grant_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational winner select, fixed priority or round-robin
//
// Ports:
//   req    in  N  request vector
//   ptr    in  W  round-robin pointer; search starts at ptr+1 when rr_en=1
//   rr_en  in  1  1 = round-robin search, 0 = lowest index wins
//   valid  out 1  some request is present
//   idx    out W  winning index
module arb_pick #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    input  logic         rr_en,
    output logic         valid,
    output logic [W-1:0] idx
);

    always_comb begin
        int         cand;
        logic [W-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        valid    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            cand     = rr_en ? ((int'(ptr) + 1 + k) % N) : k;
            cand_idx = W'(cand);
            if (!valid && req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - shares one uart transmitter among N_REQ byte sources
//
// Build option: define UART_TX_RR_EN for round-robin idle arbitration
// (default is fixed priority, index 0 highest).
//
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   req/last/byte_in    per-requester byte handshake (byte i at [8i+7:8i])
//   ack                 one-cycle pulse to the owner when its byte is done
//   transmit, tx_byte   to the uart
//   is_transmitting     from the uart
//   grant_id            current or last owner
//   busy                not idle
//   tx_timeout          pulses on each start retry
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ         = 3,
    parameter int START_TIMEOUT = DEFAULT_START_TIMEOUT,
    parameter int HOLD_TIMEOUT  = DEFAULT_HOLD_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            last,
    input  logic [8*N_REQ-1:0]          byte_in,
    output logic [N_REQ-1:0]            ack,
    output logic                        transmit,
    output logic [7:0]                  tx_byte,
    input  logic                        is_transmitting,
    output logic [grant_w(N_REQ)-1:0]   grant_id,
    output logic                        busy,
    output logic                        tx_timeout
);

    localparam int GW = grant_w(N_REQ);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    arb_state_t    state;
    logic          last_q;
    logic          lock;
    logic [31:0]   wait_cnt;
    logic [31:0]   hold_cnt;
    logic [GW-1:0] rr_ptr;
    logic          rr_en;
    logic [N_REQ-1:0] pick_req;
    logic          pick_valid;
    logic [GW-1:0] pick_idx;

    // While a string is locked only the owner's request can win.
    assign pick_req = lock ? (req & (ONE << grant_id)) : req;

    arb_pick #(
        .N (N_REQ),
        .W (GW)
    ) u_pick (
        .req   (pick_req),
        .ptr   (rr_ptr),
        .rr_en (rr_en),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

`ifdef UART_TX_RR_EN
    assign rr_en = 1'b1;

    // Pointer follows the owner of each completed string (last byte or hold expiry).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if ((state == DONE && last_q) ||
                     (state == HOLD && !pick_valid && hold_cnt == 32'(HOLD_TIMEOUT - 1))) begin
            rr_ptr <= grant_id;
        end
    end
`else
    assign rr_en  = 1'b0;
    assign rr_ptr = '0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            transmit   <= 1'b0;
            tx_byte    <= 8'h00;
            ack        <= '0;
            grant_id   <= '0;
            tx_timeout <= 1'b0;
            last_q     <= 1'b0;
            lock       <= 1'b0;
            wait_cnt   <= '0;
            hold_cnt   <= '0;
        end else begin
            ack        <= '0;
            tx_timeout <= 1'b0;
            transmit   <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        tx_byte  <= byte_in[{pick_idx, 3'b000} +: 8];
                        last_q   <= last[pick_idx];
                        transmit <= 1'b1;
                        state    <= START;
                    end else if (state == HOLD) begin
                        if (hold_cnt == 32'(HOLD_TIMEOUT - 1)) begin
                            lock  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            hold_cnt <= hold_cnt + 32'd1;
                        end
                    end
                end
                START: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (is_transmitting) begin
                        state <= SEND;
                    end else if (wait_cnt == 32'(START_TIMEOUT - 1)) begin
                        // uart missed the start pulse: pulse it again
                        tx_timeout <= 1'b1;
                        transmit   <= 1'b1;
                        state      <= START;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                SEND: begin
                    if (!is_transmitting) begin
                        ack   <= ONE << grant_id;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (last_q) begin
                        lock  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        lock     <= 1'b1;
                        hold_cnt <= '0;
                        state    <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int ST = 8;
    localparam int HT = 20;
`ifdef UART_TX_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  req = '0;
    logic [N-1:0]  last = '0;
    logic [8*N-1:0] byte_in = '0;
    logic [N-1:0]  ack;
    logic          transmit;
    logic [7:0]    tx_byte;
    logic          is_transmitting = 1'b0;
    logic [1:0]    grant_id;
    logic          busy;
    logic          tx_timeout;

    uart_tx_arbiter #(
        .N_REQ         (N),
        .START_TIMEOUT (ST),
        .HOLD_TIMEOUT  (HT)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .last            (last),
        .byte_in         (byte_in),
        .ack             (ack),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (is_transmitting),
        .grant_id        (grant_id),
        .busy            (busy),
        .tx_timeout      (tx_timeout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Requester driver: each requester walks its byte list, waiting sg cycles before a byte.
    logic [7:0] sb [N][32];
    bit         sl [N][32];
    int         sg [N][32];
    int         slen [N];
    int         spos [N];
    int         gap [N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (req[i] && ack[i]) begin
                req[i] = 1'b0;
                spos[i]++;
                if (spos[i] < slen[i]) gap[i] = sg[i][spos[i]];
            end else if (spos[i] >= slen[i]) begin
                req[i] = 1'b0;
            end
            if (!req[i] && spos[i] < slen[i]) begin
                if (gap[i] > 0) begin
                    gap[i]--;
                end else begin
                    req[i] = 1'b1;
                    byte_in[8*i +: 8] = sb[i][spos[i]];
                    last[i] = sl[i][spos[i]];
                end
            end
        end
    end

    task automatic load(input int i, input logic [7:0] b, input bit l, input int g);
        sb[i][slen[i]] = b;
        sl[i][slen[i]] = l;
        sg[i][slen[i]] = g;
        if (spos[i] == slen[i]) gap[i] = g;
        slen[i]++;
    endtask

    task automatic clear_drv();
        for (int i = 0; i < N; i++) begin
            slen[i] = 0;
            spos[i] = 0;
            gap[i]  = 0;
        end
    endtask

    // UART model: is_transmitting rises 2 cycles after an accepted start and stays 10 cycles.
    int         ignore_n = 0;
    bit         u_busy = 1'b0;
    int         u_dly = 0;
    int         u_hold = 0;
    int         cyc = 0;
    logic [7:0] got [$];
    int         tx_times [$];
    int         to_cnt = 0;
    int         ack_cnt = 0;
    int         ack_ids [$];

    always @(negedge clk) begin
        cyc++;
        if (tx_timeout) to_cnt++;
        if (transmit) begin
            tx_times.push_back(cyc);
            if (!u_busy) begin
                if (ignore_n > 0) begin
                    ignore_n--;
                end else begin
                    u_busy = 1'b1;
                    u_dly  = 2;
                    got.push_back(tx_byte);
                end
            end
        end else if (u_busy) begin
            if (u_dly > 0) begin
                u_dly--;
                if (u_dly == 0) begin
                    is_transmitting = 1'b1;
                    u_hold = 10;
                end
            end else if (u_hold > 0) begin
                u_hold--;
                if (u_hold == 0) begin
                    is_transmitting = 1'b0;
                    u_busy = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (ack !== '0) begin
            ack_cnt++;
            ack_ids.push_back(int'(grant_id));
            chk("ack_owner", 32'(ack), 32'd1 << grant_id);
        end
    end

    // Reference order: whole strings, chosen by priority or rotation among waiting requesters.
    logic [7:0] exp_b [$];
    int         exp_id [$];

    task automatic build_expected();
        int pos [N];
        int ptr;
        int left;
        int c;
        int cand;
        exp_b.delete();
        exp_id.delete();
        ptr  = 0;
        left = 0;
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            left += slen[i];
        end
        while (left > 0) begin
            c = -1;
            for (int k = 0; k < N; k++) begin
                cand = RR_MODE ? (ptr + 1 + k) % N : k;
                if (c < 0 && pos[cand] < slen[cand]) c = cand;
            end
            do begin
                exp_b.push_back(sb[c][pos[c]]);
                exp_id.push_back(c);
                pos[c]++;
                left--;
            end while (!sl[c][pos[c]-1]);
            ptr = c;
        end
    endtask

    task automatic wait_done(input string name);
        int  n = 0;
        bit  fin = 1'b0;
        while (!fin && n < 20000) begin
            @(negedge clk);
            n++;
            fin = !busy && !u_busy;
            for (int i = 0; i < N; i++) if (spos[i] < slen[i]) fin = 1'b0;
        end
        chk({name, "_completes"}, 32'(fin), 32'd1);
    endtask

    task automatic compare(input string name);
        chk({name, "_nbytes"}, got.size(), exp_b.size());
        chk({name, "_nacks"}, ack_ids.size(), exp_id.size());
        for (int k = 0; k < got.size() && k < exp_b.size(); k++)
            chk({name, "_byte"}, 32'(got[k]), 32'(exp_b[k]));
        for (int k = 0; k < ack_ids.size() && k < exp_id.size(); k++)
            chk({name, "_owner"}, ack_ids[k], exp_id[k]);
    endtask

    task automatic do_reset();
        int n = 0;
        while ((is_transmitting || u_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        clear_drv();
        ignore_n = 0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        got.delete();
        ack_ids.delete();
        tx_times.delete();
        to_cnt = 0;
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, "_transmit"}, 32'(transmit), 0);
        chk({name, "_tx_byte"}, 32'(tx_byte), 0);
        chk({name, "_ack"}, 32'(ack), 0);
        chk({name, "_grant"}, 32'(grant_id), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_tx_timeout"}, 32'(tx_timeout), 0);
    endtask

    typedef struct {
        int         idx;
        logic [7:0] b;
        logic [2:0] exp_ack;
        int         exp_grant;
    } vec_t;

    vec_t vecs [4];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        int ns;
        int len;

        vecs[0] = '{idx: 1, b: 8'h41, exp_ack: 3'b010, exp_grant: 1};
        vecs[1] = '{idx: 0, b: 8'h00, exp_ack: 3'b001, exp_grant: 0};
        vecs[2] = '{idx: 2, b: 8'hFF, exp_ack: 3'b100, exp_grant: 2};
        vecs[3] = '{idx: 1, b: 8'h5A, exp_ack: 3'b010, exp_grant: 1};
        clear_drv();

        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        reset_n = 1'b1;

        // single-byte vectors
        for (int v = 0; v < 4; v++) begin
            @(posedge clk);
            load(vecs[v].idx, vecs[v].b, 1'b1, 0);
            @(negedge clk);
            @(negedge clk);
            chk("vec_transmit_latency", 32'(transmit), 1);
            chk("vec_tx_byte", 32'(tx_byte), 32'(vecs[v].b));
            chk("vec_grant", 32'(grant_id), vecs[v].exp_grant);
            chk("vec_busy", 32'(busy), 1);
            @(negedge clk);
            chk("vec_transmit_one_cycle", 32'(transmit), 0);
            n = 0;
            while (ack === '0 && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("vec_ack", 32'(ack), 32'(vecs[v].exp_ack));
            @(negedge clk);
            chk("vec_ack_pulse", 32'(ack), 0);
            chk("vec_idle", 32'(busy), 0);
        end

        // simultaneous requests 0 and 2
        do_reset();
        load(0, 8'hA0, 1'b1, 0);
        load(2, 8'hA2, 1'b1, 0);
        build_expected();
        wait_done("simul");
        compare("simul");

        // locked string with an echo waiting behind it
        do_reset();
        load(2, 8'h0D, 1'b0, 0);
        load(2, 8'h0A, 1'b0, 3);
        load(2, 8'h54, 1'b1, 0);
        repeat (4) @(posedge clk);
        load(0, 8'h35, 1'b1, 0);
        exp_b  = '{8'h0D, 8'h0A, 8'h54, 8'h35};
        exp_id = '{2, 2, 2, 0};
        wait_done("lock");
        compare("lock");

        // start timeout: uart ignores three start pulses
        do_reset();
        ignore_n = 3;
        load(1, 8'h5C, 1'b1, 0);
        base = ack_cnt;
        wait_done("start_to");
        chk("start_to_count", to_cnt, 3);
        chk("start_to_pulses", tx_times.size(), 4);
        for (int k = 1; k < tx_times.size(); k++)
            chk("start_to_spacing", tx_times[k] - tx_times[k-1], ST + 1);
        chk("start_to_acks", ack_cnt - base, 1);
        chk("start_to_nbytes", got.size(), 1);
        if (got.size() > 0) chk("start_to_byte", 32'(got[0]), 32'h5C);

        // hold timeout: owner stops mid-string, requester 0 stalls behind the lock
        do_reset();
        load(1, 8'h11, 1'b0, 0);
        repeat (4) @(posedge clk);
        load(0, 8'h22, 1'b1, 0);
        n = 0;
        while (ack[1] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_first_ack", 32'(ack), 32'b010);
        n = 0;
        base = 0;
        while (transmit !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (!busy) base++;
        end
        // HT cycles in HOLD, one in IDLE, then START
        chk("hold_stall_cycles", n, HT + 2);
        chk("hold_busy_in_stall", base, 1);
        chk("hold_new_grant", 32'(grant_id), 0);
        chk("hold_new_byte", 32'(tx_byte), 32'h22);
        wait_done("hold");

        // reset while the uart is sending
        do_reset();
        load(1, 8'h77, 1'b1, 0);
        n = 0;
        while (is_transmitting !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reached_send", 32'(is_transmitting), 1);
        repeat (2) @(negedge clk);
        @(posedge clk);
        clear_drv();
        @(negedge clk);
        reset_n = 1'b0;
        base = ack_cnt;
        @(negedge clk);
        chk_reset_values("rst_mid");
        reset_n = 1'b1;
        n = 0;
        while (u_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("rst_no_ack", ack_cnt - base, 0);
        @(posedge clk);
        load(1, 8'h78, 1'b1, 0);
        wait_done("rst_reissue");
        chk("rst_reissue_ack", ack_cnt - base, 1);
        if (got.size() > 0) chk("rst_reissue_byte", 32'(got[got.size()-1]), 32'h78);

        // randomized strings against the reference order
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                ns = $urandom_range(1, 3);
                for (int s = 0; s < ns; s++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++)
                        load(i, 8'($urandom), b == len - 1, (b == 0) ? 0 : $urandom_range(0, 4));
                end
            end
            build_expected();
            wait_done("rand");
            compare("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
